mem_arbiter: RTL

Two-requester arbiter sharing one single-ported, variable-latency memory between the hart's instruction-fetch port and data (load/store) port. It sits between the hart and a unified memory and serializes accesses, one outstanding transaction at a time. Data accesses have priority; a starvation counter bounds how long fetch can be locked out. Completions are returned to the owning requester through a registered one-cycle acknowledge.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arb_select.sv | 29 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the fetch/data memory arbiter.
// Core widths live here so every arbiter file agrees on them.
package mem_arbiter_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned INSTR_LEN          = 32;
    localparam int unsigned MEM_ARB_OWNER_BITS = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_D  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational eligibility and priority pick between fetch and data requesters.
// The caller only samples the grants while the arbiter is idle.
module mem_arb_select #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STREAK_W     = 3
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic                if_ack,
    input  logic                d_ack,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if_c,
    output logic                grant_d_c
);

    logic if_elig;
    logic d_elig;
    logic starved;

    // A port whose ack is showing this cycle is still retiring and may not re-win.
    always_comb begin
        if_elig    = if_req & ~if_ack;
        d_elig     = d_req & ~d_ack;
        starved    = (streak == STREAK_W'(STARVE_LIMIT));
        grant_d_c  = d_elig & ~(if_elig & starved);
        grant_if_c = if_elig & ~grant_d_c;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and load/store accesses onto one variable-latency memory port.
// Data wins ties; a streak counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [XLEN-1:0]      if_addr,
    output logic                 if_ack,
    output logic [INSTR_LEN-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [XLEN-1:0]      d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    output logic                 d_ack,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ready,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t           state_q,     state_d;
    logic [STREAK_W-1:0]  streak_q,    streak_d;
    logic                 mem_req_q,   mem_req_d;
    logic                 mem_we_q,    mem_we_d;
    logic [XLEN-1:0]      mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
    logic                 if_ack_q,    if_ack_d;
    logic                 d_ack_q,     d_ack_d;
    logic [INSTR_LEN-1:0] if_rdata_q,  if_rdata_d;
    logic [XLEN-1:0]      d_rdata_q,   d_rdata_d;

    logic grant_if_c;
    logic grant_d_c;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .STREAK_W     (STREAK_W)
    ) u_select (
        .if_req     (if_req),
        .d_req      (d_req),
        .if_ack     (if_ack_q),
        .d_ack      (d_ack_q),
        .streak     (streak_q),
        .grant_if_c (grant_if_c),
        .grant_d_c  (grant_d_c)
    );

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d     = SERVE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Streak only grows while a fetch is actually waiting.
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(STARVE_LIMIT)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (grant_if_c) begin
                    state_d     = SERVE_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            SERVE_IF: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata[INSTR_LEN-1:0];
                end
            end
            SERVE_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Reset drops any in-flight access without acknowledging it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;

endmodule
